// File: rtl/param_issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// param_issue_queue_pkg
//   Shared types, constants and helpers for the parametrised issue queue.
//   - AL_SIZE / IQ_*_W : active-list size and the default field widths.
//   - MODE_OOO / MODE_INORDER : select-policy constants for the MODE parameter.
//   - iq_entry_t : default-width layout of one queue entry, as seen by the
//     rename and execute stages.
//   - al_age() : distance of an active-list slot from a reference slot,
//     modulo AL_SIZE.
// ---------------------------------------------------------------------------
package param_issue_queue_pkg;

  localparam int AL_SIZE      = 32;
  localparam int IQ_AL_W      = $clog2(AL_SIZE);
  localparam int IQ_PREG_W    = 7;
  localparam int IQ_PAYLOAD_W = 32;

  localparam int MODE_OOO     = 0;
  localparam int MODE_INORDER = 1;

  typedef struct packed {
    logic                    valid;
    logic [IQ_PREG_W-1:0]    src1;
    logic                    src1Rdy;
    logic [IQ_PREG_W-1:0]    src2;
    logic                    src2Rdy;
    logic [IQ_PREG_W-1:0]    dst;
    logic [IQ_AL_W-1:0]      alAddr;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;

  // AL_SIZE is a power of two, so the modulo is plain wrap-around of the
  // AL_W-bit subtraction.
  function automatic logic [IQ_AL_W-1:0] al_age(input logic [IQ_AL_W-1:0] slot,
                                                input logic [IQ_AL_W-1:0] base);
    return slot - base;
  endfunction

endpackage

// File: rtl/param_issue_queue_select.sv
// ---------------------------------------------------------------------------
// iq_age_select
//   Combinational oldest-first picker.
//   Ports:
//     req_i     : per-entry issue request (valid and both sources ready)
//     valid_i   : per-entry occupancy, used as the candidate set in order
//     age_i     : per-entry age, smaller is older
//     inorder_i : 0 = pick the ISSUE_W oldest requesters,
//                 1 = walk the ISSUE_W oldest valid entries and stop at the
//                     first one that is not requesting
//     grant_o   : ISSUE_W one-hot grant vectors, port 0 holds the oldest
// ---------------------------------------------------------------------------
module iq_age_select #(
  parameter int DEPTH   = 16,
  parameter int ISSUE_W = 2,
  parameter int AGE_W   = 5
) (
  input  logic [DEPTH-1:0]              req_i,
  input  logic [DEPTH-1:0]              valid_i,
  input  logic [DEPTH-1:0][AGE_W-1:0]   age_i,
  input  logic                          inorder_i,
  output logic [ISSUE_W-1:0][DEPTH-1:0] grant_o
);

  // Each port repeatedly takes the oldest untaken candidate. In order, a
  // non-requesting oldest entry blocks every younger port.
  always_comb begin
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] taken;
    logic [DEPTH-1:0] pickOh;
    logic [AGE_W-1:0] bestAge;
    logic             found;
    logic             blocked;
    cand    = inorder_i ? valid_i : req_i;
    taken   = '0;
    blocked = 1'b0;
    grant_o = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      found   = 1'b0;
      bestAge = '0;
      pickOh  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (cand[i] && !taken[i] && (!found || (age_i[i] < bestAge))) begin
          found     = 1'b1;
          bestAge   = age_i[i];
          pickOh    = '0;
          pickOh[i] = 1'b1;
        end
      end
      if (found && !blocked) begin
        taken = taken | pickOh;
        if ((pickOh & req_i) != '0) begin
          grant_o[k] = pickOh;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/param_issue_queue.sv
// ---------------------------------------------------------------------------
// param_issue_queue
//   Age-ordered issue queue shared by the ALU and memory pipes. Accepts up to
//   DISPATCH_W renamed ops per cycle, wakes sources from writeback tags,
//   issues up to ISSUE_W ops per cycle oldest-ready first (MODE 0) or as an
//   in-order ready prefix (MODE 1), and squashes on branch recall.
//   Ports:
//     clk, reset            : clock, synchronous active-low reset
//     ext_stall             : downstream stall, holds the issue registers
//     i_valid .. i_payload  : dispatch lanes
//     i_wb_valid, i_wb_tag  : writeback wakeup ports
//     if_recall             : squash request for the range new_front..old_front
//     new_front, old_front  : recall range bounds in the active list
//     back                  : oldest active-list slot, the age reference
//     o_valid .. o_payload  : registered issue ports
//     int_stall             : dispatch back-pressure (all-or-nothing)
// ---------------------------------------------------------------------------
module param_issue_queue
  import param_issue_queue_pkg::*;
#(
  parameter int DISPATCH_W = 2,
  parameter int ISSUE_W    = 2,
  parameter int WB_W       = 4,
  parameter int DEPTH      = 16,
  parameter int PREG_W     = IQ_PREG_W,
  parameter int AL_W       = $clog2(AL_SIZE),
  parameter int PAYLOAD_W  = IQ_PAYLOAD_W,
  parameter int MODE       = MODE_OOO
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 ext_stall,
  input  logic [DISPATCH_W-1:0]                i_valid,
  input  logic [DISPATCH_W-1:0][PREG_W-1:0]    i_src1,
  input  logic [DISPATCH_W-1:0][PREG_W-1:0]    i_src2,
  input  logic [DISPATCH_W-1:0]                i_src1_rdy,
  input  logic [DISPATCH_W-1:0]                i_src2_rdy,
  input  logic [DISPATCH_W-1:0][PREG_W-1:0]    i_dst,
  input  logic [DISPATCH_W-1:0][AL_W-1:0]      i_al_addr,
  input  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] i_payload,
  input  logic [WB_W-1:0]                      i_wb_valid,
  input  logic [WB_W-1:0][PREG_W-1:0]          i_wb_tag,
  input  logic                                 if_recall,
  input  logic [AL_W-1:0]                      new_front,
  input  logic [AL_W-1:0]                      old_front,
  input  logic [AL_W-1:0]                      back,
  output logic [ISSUE_W-1:0]                   o_valid,
  output logic [ISSUE_W-1:0][PREG_W-1:0]       o_src1,
  output logic [ISSUE_W-1:0][PREG_W-1:0]       o_src2,
  output logic [ISSUE_W-1:0][PREG_W-1:0]       o_dst,
  output logic [ISSUE_W-1:0][AL_W-1:0]         o_al_addr,
  output logic [ISSUE_W-1:0][PAYLOAD_W-1:0]    o_payload,
  output logic                                 int_stall
);

  localparam int                 CNT_W        = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]   DISPATCH_CNT = CNT_W'(DISPATCH_W);
  localparam logic               IN_ORDER     = (MODE == MODE_INORDER);

  // Queue entry at the module's own widths; mirrors iq_entry_t.
  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    src1;
    logic                 src1Rdy;
    logic [PREG_W-1:0]    src2;
    logic                 src2Rdy;
    logic [PREG_W-1:0]    dst;
    logic [AL_W-1:0]      alAddr;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  // Issue register contents; ready bits are implied once issued.
  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    src1;
    logic [PREG_W-1:0]    src2;
    logic [PREG_W-1:0]    dst;
    logic [AL_W-1:0]      alAddr;
    logic [PAYLOAD_W-1:0] payload;
  } out_t;

  entry_t entry_q [DEPTH];
  entry_t entry_d [DEPTH];
  out_t   out_q   [ISSUE_W];
  out_t   out_d   [ISSUE_W];
  entry_t newEntry [DISPATCH_W];

  logic [CNT_W-1:0]                freeCount;
  logic [DEPTH-1:0]                reqVec;
  logic [DEPTH-1:0]                validVec;
  logic [DEPTH-1:0][AL_W-1:0]      ageVec;
  logic [DEPTH-1:0]                entrySquash;
  logic [ISSUE_W-1:0][DEPTH-1:0]   grantVec;
  logic [DEPTH-1:0]                grantAny;
  logic [DISPATCH_W-1:0][DEPTH-1:0] allocOh;
  logic [AL_W-1:0]                 recallSpan;
  logic                            dispatchEn;
  logic                            issueEn;

  function automatic logic tagHit(input logic [PREG_W-1:0]           tag,
                                  input logic [WB_W-1:0]             wbValid,
                                  input logic [WB_W-1:0][PREG_W-1:0] wbTag);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WB_W; w++) begin
      if (wbValid[w] && (wbTag[w] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Occupancy drives back-pressure; the stall is computed from registered
  // state only, so a full queue refuses a whole dispatch group.
  always_comb begin
    freeCount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!entry_q[i].valid) freeCount = freeCount + CNT_W'(1);
    end
  end

  assign int_stall  = ext_stall | (freeCount < DISPATCH_CNT);
  assign dispatchEn = !int_stall && !if_recall;
  assign issueEn    = !ext_stall && !if_recall;
  assign recallSpan = al_age(old_front, new_front);

  // Per-entry request, age relative to the oldest slot, and recall hit.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      validVec[i]    = entry_q[i].valid;
      reqVec[i]      = entry_q[i].valid & entry_q[i].src1Rdy & entry_q[i].src2Rdy;
      ageVec[i]      = al_age(entry_q[i].alAddr, back);
      entrySquash[i] = al_age(entry_q[i].alAddr, new_front) < recallSpan;
    end
  end

  iq_age_select #(
    .DEPTH   (DEPTH),
    .ISSUE_W (ISSUE_W),
    .AGE_W   (AL_W)
  ) u_select (
    .req_i     (reqVec),
    .valid_i   (validVec),
    .age_i     (ageVec),
    .inorder_i (IN_ORDER),
    .grant_o   (grantVec)
  );

  always_comb begin
    grantAny = '0;
    for (int k = 0; k < ISSUE_W; k++) grantAny = grantAny | grantVec[k];
  end

  // Valid lanes claim free slots lowest index first, in lane order; an
  // invalid lane claims nothing so a later lane can use the lowest slot.
  always_comb begin
    logic [DEPTH-1:0] taken;
    logic             found;
    taken   = '0;
    allocOh = '0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (i_valid[l] && !found && !entry_q[i].valid && !taken[i]) begin
          found         = 1'b1;
          allocOh[l][i] = 1'b1;
          taken[i]      = 1'b1;
        end
      end
    end
  end

  // Incoming ops see same-cycle writebacks so they can issue next edge.
  always_comb begin
    for (int l = 0; l < DISPATCH_W; l++) begin
      newEntry[l].valid   = 1'b1;
      newEntry[l].src1    = i_src1[l];
      newEntry[l].src1Rdy = i_src1_rdy[l] | tagHit(i_src1[l], i_wb_valid, i_wb_tag);
      newEntry[l].src2    = i_src2[l];
      newEntry[l].src2Rdy = i_src2_rdy[l] | tagHit(i_src2[l], i_wb_valid, i_wb_tag);
      newEntry[l].dst     = i_dst[l];
      newEntry[l].alAddr  = i_al_addr[l];
      newEntry[l].payload = i_payload[l];
    end
  end

  // Entry update: wakeup always, then squash or issue frees the slot, then
  // dispatch fills slots that were free in the registered state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid) begin
        if (tagHit(entry_q[i].src1, i_wb_valid, i_wb_tag)) entry_d[i].src1Rdy = 1'b1;
        if (tagHit(entry_q[i].src2, i_wb_valid, i_wb_tag)) entry_d[i].src2Rdy = 1'b1;
        if (if_recall && entrySquash[i]) begin
          entry_d[i].valid = 1'b0;
        end else if (issueEn && grantAny[i]) begin
          entry_d[i].valid = 1'b0;
        end
      end
      for (int l = 0; l < DISPATCH_W; l++) begin
        if (dispatchEn && allocOh[l][i]) entry_d[i] = newEntry[l];
      end
    end
  end

  // Issue registers: recall clears everything not held by the stall, and a
  // held slot survives only if it lies outside the recall range.
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      out_d[k] = out_q[k];
      if (if_recall) begin
        if (!ext_stall || (al_age(out_q[k].alAddr, new_front) < recallSpan)) begin
          out_d[k].valid = 1'b0;
        end
      end else if (!ext_stall) begin
        out_d[k]       = '0;
        out_d[k].valid = |grantVec[k];
        for (int i = 0; i < DEPTH; i++) begin
          if (grantVec[k][i]) begin
            out_d[k].src1    = entry_q[i].src1;
            out_d[k].src2    = entry_q[i].src2;
            out_d[k].dst     = entry_q[i].dst;
            out_d[k].alAddr  = entry_q[i].alAddr;
            out_d[k].payload = entry_q[i].payload;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      for (int k = 0; k < ISSUE_W; k++) out_q[k] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      for (int k = 0; k < ISSUE_W; k++) out_q[k] <= out_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      o_valid[k]   = out_q[k].valid;
      o_src1[k]    = out_q[k].src1;
      o_src2[k]    = out_q[k].src2;
      o_dst[k]     = out_q[k].dst;
      o_al_addr[k] = out_q[k].alAddr;
      o_payload[k] = out_q[k].payload;
    end
  end

endmodule

// File: tb/tb_param_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_param_issue_queue
//   Directed bench for param_issue_queue. Two instances share every input:
//   dutA runs out-of-order select, dutB runs in-order select.
// ---------------------------------------------------------------------------
module tb_param_issue_queue;

  localparam int DW = 2;
  localparam int IW = 2;
  localparam int WW = 4;
  localparam int PW = 7;
  localparam int AW = 5;
  localparam int LW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ext_stall, if_recall;
  logic [DW-1:0]         i_valid, i_src1_rdy, i_src2_rdy;
  logic [DW-1:0][PW-1:0] i_src1, i_src2, i_dst;
  logic [DW-1:0][AW-1:0] i_al_addr;
  logic [DW-1:0][LW-1:0] i_payload;
  logic [WW-1:0]         i_wb_valid;
  logic [WW-1:0][PW-1:0] i_wb_tag;
  logic [AW-1:0]         new_front, old_front, back;

  logic [IW-1:0]         oValidA, oValidB;
  logic [IW-1:0][PW-1:0] oSrc1A, oSrc2A, oDstA, oSrc1B, oSrc2B, oDstB;
  logic [IW-1:0][AW-1:0] oAlA, oAlB;
  logic [IW-1:0][LW-1:0] oPayA, oPayB;
  logic                  intStallA, intStallB;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_issue_queue #(.MODE(0)) dutA (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .i_valid(i_valid),
    .i_src1(i_src1), .i_src2(i_src2), .i_src1_rdy(i_src1_rdy), .i_src2_rdy(i_src2_rdy),
    .i_dst(i_dst), .i_al_addr(i_al_addr), .i_payload(i_payload),
    .i_wb_valid(i_wb_valid), .i_wb_tag(i_wb_tag), .if_recall(if_recall),
    .new_front(new_front), .old_front(old_front), .back(back),
    .o_valid(oValidA), .o_src1(oSrc1A), .o_src2(oSrc2A), .o_dst(oDstA),
    .o_al_addr(oAlA), .o_payload(oPayA), .int_stall(intStallA));

  param_issue_queue #(.MODE(1)) dutB (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .i_valid(i_valid),
    .i_src1(i_src1), .i_src2(i_src2), .i_src1_rdy(i_src1_rdy), .i_src2_rdy(i_src2_rdy),
    .i_dst(i_dst), .i_al_addr(i_al_addr), .i_payload(i_payload),
    .i_wb_valid(i_wb_valid), .i_wb_tag(i_wb_tag), .if_recall(if_recall),
    .new_front(new_front), .old_front(old_front), .back(back),
    .o_valid(oValidB), .o_src1(oSrc1B), .o_src2(oSrc2B), .o_dst(oDstB),
    .o_al_addr(oAlB), .o_payload(oPayB), .int_stall(intStallB));

  // Deasserts every per-cycle request; range/back registers are left alone.
  task automatic clearInputs();
    ext_stall  = 1'b0;
    if_recall  = 1'b0;
    i_valid    = '0;
    i_src1     = '0;
    i_src2     = '0;
    i_src1_rdy = '0;
    i_src2_rdy = '0;
    i_dst      = '0;
    i_al_addr  = '0;
    i_payload  = '0;
    i_wb_valid = '0;
    i_wb_tag   = '0;
  endtask

  // Loads one dispatch lane.
  task automatic applyStimulus(input int lane, input logic [PW-1:0] s1, input logic r1,
                               input logic [PW-1:0] s2, input logic r2, input logic [PW-1:0] dst,
                               input logic [AW-1:0] al, input logic [LW-1:0] pay);
    i_valid[lane]    = 1'b1;
    i_src1[lane]     = s1;
    i_src1_rdy[lane] = r1;
    i_src2[lane]     = s2;
    i_src2_rdy[lane] = r2;
    i_dst[lane]      = dst;
    i_al_addr[lane]  = al;
    i_payload[lane]  = pay;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clearInputs();
    new_front = '0;
    old_front = '0;
    back      = '0;
    reset     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL reset_valid_a got=%b want=00", oValidA); end
    checks++; if (oValidB !== 2'b00) begin failures++; $display("[TB] FAIL reset_valid_b got=%b want=00", oValidB); end
    checks++; if (oAlA !== '0) begin failures++; $display("[TB] FAIL reset_al got=%h want=0", oAlA); end
    checks++; if (oPayA !== '0) begin failures++; $display("[TB] FAIL reset_payload got=%h want=0", oPayA); end
    checks++; if (intStallA !== 1'b0) begin failures++; $display("[TB] FAIL reset_int_stall got=%b want=0", intStallA); end
    ext_stall = 1'b1;
    #1;
    checks++; if (intStallA !== 1'b1) begin failures++; $display("[TB] FAIL reset_int_stall_follows_ext got=%b want=1", intStallA); end
    ext_stall = 1'b0;
    #1;
  endtask

  task automatic test_dispatch_issue();
    doReset();
    applyStimulus(0, 7'd1, 1'b1, 7'd2, 1'b1, 7'd10, 5'd3, 32'hA000_0003);
    applyStimulus(1, 7'd1, 1'b1, 7'd2, 1'b1, 7'd11, 5'd4, 32'hA000_0004);
    tick();
    clearInputs();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL disp_n_valid got=%b want=00", oValidA); end
    tick();
    checks++; if (oValidA !== 2'b11) begin failures++; $display("[TB] FAIL disp_n1_valid got=%b want=11", oValidA); end
    checks++; if (oAlA[0] !== 5'd3) begin failures++; $display("[TB] FAIL disp_al0 got=%0d want=3", oAlA[0]); end
    checks++; if (oAlA[1] !== 5'd4) begin failures++; $display("[TB] FAIL disp_al1 got=%0d want=4", oAlA[1]); end
    checks++; if (oDstA[0] !== 7'd10) begin failures++; $display("[TB] FAIL disp_dst0 got=%0d want=10", oDstA[0]); end
    checks++; if (oDstA[1] !== 7'd11) begin failures++; $display("[TB] FAIL disp_dst1 got=%0d want=11", oDstA[1]); end
    checks++; if (oPayA[1] !== 32'hA000_0004) begin failures++; $display("[TB] FAIL disp_payload1 got=%h want=a0000004", oPayA[1]); end
    checks++; if (oValidB !== 2'b11) begin failures++; $display("[TB] FAIL disp_inorder_valid got=%b want=11", oValidB); end
    checks++; if (oAlB[0] !== 5'd3) begin failures++; $display("[TB] FAIL disp_inorder_al0 got=%0d want=3", oAlB[0]); end
    tick();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL disp_empty_valid got=%b want=00", oValidA); end
  endtask

  task automatic test_select_modes();
    doReset();
    applyStimulus(0, 7'd9, 1'b0, 7'd1, 1'b1, 7'd12, 5'd5, 32'h5);
    applyStimulus(1, 7'd2, 1'b1, 7'd3, 1'b1, 7'd13, 5'd6, 32'h6);
    tick();
    clearInputs();
    tick();
    checks++; if (oValidA !== 2'b01) begin failures++; $display("[TB] FAIL ooo_first_valid got=%b want=01", oValidA); end
    checks++; if (oAlA[0] !== 5'd6) begin failures++; $display("[TB] FAIL ooo_first_al got=%0d want=6", oAlA[0]); end
    checks++; if (oValidB !== 2'b00) begin failures++; $display("[TB] FAIL ino_blocked_valid got=%b want=00", oValidB); end
    i_wb_valid[0] = 1'b1;
    i_wb_tag[0]   = 7'd9;
    tick();
    clearInputs();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL ooo_wake_edge_valid got=%b want=00", oValidA); end
    checks++; if (oValidB !== 2'b00) begin failures++; $display("[TB] FAIL ino_wake_edge_valid got=%b want=00", oValidB); end
    tick();
    checks++; if (oValidA !== 2'b01) begin failures++; $display("[TB] FAIL ooo_second_valid got=%b want=01", oValidA); end
    checks++; if (oAlA[0] !== 5'd5) begin failures++; $display("[TB] FAIL ooo_second_al got=%0d want=5", oAlA[0]); end
    checks++; if (oValidB !== 2'b11) begin failures++; $display("[TB] FAIL ino_pair_valid got=%b want=11", oValidB); end
    checks++; if (oAlB[0] !== 5'd5) begin failures++; $display("[TB] FAIL ino_pair_al0 got=%0d want=5", oAlB[0]); end
    checks++; if (oAlB[1] !== 5'd6) begin failures++; $display("[TB] FAIL ino_pair_al1 got=%0d want=6", oAlB[1]); end
    tick();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL ooo_drain_valid got=%b want=00", oValidA); end
    checks++; if (oValidB !== 2'b00) begin failures++; $display("[TB] FAIL ino_drain_valid got=%b want=00", oValidB); end
  endtask

  task automatic test_full();
    doReset();
    for (int n = 0; n < 7; n++) begin
      applyStimulus(0, 7'(20 + 2 * n), 1'b0, 7'd1, 1'b1, 7'd40, 5'(2 * n), 32'(2 * n));
      applyStimulus(1, 7'(21 + 2 * n), 1'b0, 7'd1, 1'b1, 7'd40, 5'(2 * n + 1), 32'(2 * n + 1));
      tick();
    end
    clearInputs();
    #1;
    checks++; if (intStallA !== 1'b0) begin failures++; $display("[TB] FAIL full_14_int_stall got=%b want=0", intStallA); end
    applyStimulus(0, 7'd34, 1'b0, 7'd1, 1'b1, 7'd40, 5'd14, 32'd14);
    tick();
    clearInputs();
    #1;
    checks++; if (intStallA !== 1'b1) begin failures++; $display("[TB] FAIL full_15_int_stall got=%b want=1", intStallA); end
    applyStimulus(0, 7'd1, 1'b1, 7'd2, 1'b1, 7'd41, 5'd20, 32'hDEAD);
    i_wb_valid[0] = 1'b1;
    i_wb_tag[0]   = 7'd20;
    tick();
    i_wb_valid = '0;
    checks++; if (intStallA !== 1'b1) begin failures++; $display("[TB] FAIL full_wake_int_stall got=%b want=1", intStallA); end
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL full_wake_valid got=%b want=00", oValidA); end
    tick();
    clearInputs();
    #1;
    checks++; if (oValidA !== 2'b01) begin failures++; $display("[TB] FAIL full_issue_valid got=%b want=01", oValidA); end
    checks++; if (oAlA[0] !== 5'd0) begin failures++; $display("[TB] FAIL full_issue_al got=%0d want=0", oAlA[0]); end
    checks++; if (intStallA !== 1'b0) begin failures++; $display("[TB] FAIL full_release_int_stall got=%b want=0", intStallA); end
  endtask

  task automatic test_recall();
    doReset();
    back = 5'd8;
    applyStimulus(0, 7'd50, 1'b0, 7'd1, 1'b1, 7'd60, 5'd10, 32'd10);
    applyStimulus(1, 7'd51, 1'b0, 7'd1, 1'b1, 7'd60, 5'd30, 32'd30);
    tick();
    clearInputs();
    applyStimulus(0, 7'd52, 1'b0, 7'd1, 1'b1, 7'd60, 5'd1, 32'd1);
    applyStimulus(1, 7'd53, 1'b0, 7'd1, 1'b1, 7'd60, 5'd4, 32'd4);
    tick();
    clearInputs();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL recall_pre_valid got=%b want=00", oValidA); end
    if_recall  = 1'b1;
    new_front  = 5'd8;
    old_front  = 5'd2;
    i_wb_valid = 4'b1111;
    i_wb_tag   = {7'd53, 7'd52, 7'd51, 7'd50};
    applyStimulus(0, 7'd1, 1'b1, 7'd2, 1'b1, 7'd61, 5'd12, 32'hC);
    tick();
    clearInputs();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL recall_edge_valid got=%b want=00", oValidA); end
    tick();
    checks++; if (oValidA !== 2'b01) begin failures++; $display("[TB] FAIL recall_survivor_valid got=%b want=01", oValidA); end
    checks++; if (oAlA[0] !== 5'd4) begin failures++; $display("[TB] FAIL recall_survivor_al got=%0d want=4", oAlA[0]); end
    tick();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL recall_drain_valid got=%b want=00", oValidA); end
  endtask

  task automatic test_recall_stall();
    doReset();
    back = 5'd8;
    applyStimulus(0, 7'd1, 1'b1, 7'd2, 1'b1, 7'd70, 5'd10, 32'd10);
    applyStimulus(1, 7'd1, 1'b1, 7'd2, 1'b1, 7'd71, 5'd4, 32'd4);
    tick();
    clearInputs();
    tick();
    checks++; if (oValidA !== 2'b11) begin failures++; $display("[TB] FAIL rstall_issue_valid got=%b want=11", oValidA); end
    checks++; if (oAlA[0] !== 5'd10) begin failures++; $display("[TB] FAIL rstall_issue_al0 got=%0d want=10", oAlA[0]); end
    ext_stall = 1'b1;
    if_recall = 1'b1;
    new_front = 5'd8;
    old_front = 5'd2;
    tick();
    checks++; if (oValidA !== 2'b10) begin failures++; $display("[TB] FAIL rstall_squash_valid got=%b want=10", oValidA); end
    checks++; if (oAlA[1] !== 5'd4) begin failures++; $display("[TB] FAIL rstall_hold_al1 got=%0d want=4", oAlA[1]); end
    if_recall = 1'b0;
    tick();
    checks++; if (oValidA !== 2'b10) begin failures++; $display("[TB] FAIL rstall_hold_valid got=%b want=10", oValidA); end
    ext_stall = 1'b0;
    tick();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL rstall_release_valid got=%b want=00", oValidA); end
  endtask

  task automatic test_stall_bypass();
    doReset();
    applyStimulus(0, 7'd1, 1'b1, 7'd2, 1'b1, 7'd80, 5'd7, 32'h7);
    tick();
    clearInputs();
    applyStimulus(0, 7'd60, 1'b0, 7'd2, 1'b1, 7'd81, 5'd8, 32'h8);
    i_wb_valid[1] = 1'b1;
    i_wb_tag[1]   = 7'd60;
    tick();
    clearInputs();
    checks++; if (oValidA !== 2'b01) begin failures++; $display("[TB] FAIL bypass_first_valid got=%b want=01", oValidA); end
    checks++; if (oAlA[0] !== 5'd7) begin failures++; $display("[TB] FAIL bypass_first_al got=%0d want=7", oAlA[0]); end
    ext_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (oValidA !== 2'b01) begin failures++; $display("[TB] FAIL stall_hold_valid cycle=%0d got=%b want=01", c, oValidA); end
      checks++; if (oAlA[0] !== 5'd7) begin failures++; $display("[TB] FAIL stall_hold_al cycle=%0d got=%0d want=7", c, oAlA[0]); end
      checks++; if (intStallA !== 1'b1) begin failures++; $display("[TB] FAIL stall_int_stall cycle=%0d got=%b want=1", c, intStallA); end
    end
    ext_stall = 1'b0;
    tick();
    checks++; if (oValidA !== 2'b01) begin failures++; $display("[TB] FAIL bypass_issue_valid got=%b want=01", oValidA); end
    checks++; if (oAlA[0] !== 5'd8) begin failures++; $display("[TB] FAIL bypass_issue_al got=%0d want=8", oAlA[0]); end
    checks++; if (oSrc1A[0] !== 7'd60) begin failures++; $display("[TB] FAIL bypass_issue_src1 got=%0d want=60", oSrc1A[0]); end
    tick();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL bypass_drain_valid got=%b want=00", oValidA); end
  endtask

  task automatic test_reset_mid();
    doReset();
    applyStimulus(0, 7'd1, 1'b1, 7'd2, 1'b1, 7'd90, 5'd3, 32'h3);
    applyStimulus(1, 7'd1, 1'b1, 7'd2, 1'b1, 7'd91, 5'd4, 32'h4);
    tick();
    clearInputs();
    tick();
    checks++; if (oValidA !== 2'b11) begin failures++; $display("[TB] FAIL mid_pre_valid got=%b want=11", oValidA); end
    reset = 1'b0;
    applyStimulus(0, 7'd1, 1'b1, 7'd2, 1'b1, 7'd92, 5'd9, 32'h9);
    i_wb_valid[0] = 1'b1;
    i_wb_tag[0]   = 7'd5;
    tick();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL mid_reset_valid got=%b want=00", oValidA); end
    checks++; if (oAlA !== '0) begin failures++; $display("[TB] FAIL mid_reset_al got=%h want=0", oAlA); end
    checks++; if (oPayA !== '0) begin failures++; $display("[TB] FAIL mid_reset_payload got=%h want=0", oPayA); end
    reset = 1'b1;
    clearInputs();
    tick();
    checks++; if (oValidA !== 2'b00) begin failures++; $display("[TB] FAIL mid_after_valid got=%b want=00", oValidA); end
    checks++; if (intStallA !== 1'b0) begin failures++; $display("[TB] FAIL mid_after_int_stall got=%b want=0", intStallA); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clearInputs();
    new_front = '0;
    old_front = '0;
    back      = '0;
    test_reset();
    test_dispatch_issue();
    test_select_modes();
    test_full();
    test_recall();
    test_recall_stall();
    test_stall_bypass();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
